// File: rtl/dot8_accum_seq.sv
// dot8_accum_seq: drives an external pipelined int8 dot-product PE over a K-word
// operand stream and accumulates the partial sums. Define DOT8_ACC_SAT_EN for a saturating accumulate and sat_flag_o.
module dot8_accum_seq #(
  parameter int LATENCY   = 2,
  parameter int MAX_LEN   = 64,
  parameter int TAG_WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len_i,
  input  logic [31:0]                  cmd_init_i,
  input  logic [TAG_WIDTH-1:0]         cmd_tag_i,
  input  logic                         op_valid_i,
  output logic                         op_ready_o,
  input  logic [31:0]                  op_a_i,
  input  logic [31:0]                  op_b_i,
  output logic                         pe_enable_o,
  output logic [31:0]                  pe_a_o,
  output logic [31:0]                  pe_b_o,
  input  logic [31:0]                  pe_result_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [31:0]                  res_data_o,
  output logic [TAG_WIDTH-1:0]         res_tag_o
`ifdef DOT8_ACC_SAT_EN
  ,
  output logic                         sat_flag_o
`endif
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // ISSUE | feeding operands (or bubbles) into the PE every cycle
  // DRAIN | operands done, advancing the PE until the last result is summed
  // DONE  | result presented, held until res_ready

  localparam int LEN_W = $clog2(MAX_LEN+1);
  localparam int OUT_W = $clog2(LATENCY+1);
  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t               state_q;
  logic                 cmd_ready_q;
  logic                 op_ready_q;
  logic                 pe_enable_q;
  logic                 res_valid_q;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic [LEN_W-1:0]     len_clamped;
  logic [OUT_W-1:0]     out_q, out_d;
  logic [LATENCY-1:0]   vld_q, vld_d;
  logic [31:0]          acc_q, acc_d, acc_sum;
  logic [31:0]          res_data_q;
  logic [TAG_WIDTH-1:0] tag_q, res_tag_q;
  logic                 cmd_fire, op_fire, acc_hit, res_fire;
`ifdef DOT8_ACC_SAT_EN
  logic [32:0]          sum_ext;
  logic                 sat_hit;
  logic                 sat_q, sat_d;
`endif

  always_comb begin
    cmd_fire    = cmd_valid_i & cmd_ready_q;
    op_fire     = op_valid_i & op_ready_q;
    acc_hit     = vld_q[LATENCY-1] & pe_enable_q;
    res_fire    = res_valid_q & res_ready_i;
    len_clamped = (cmd_len_i > MAX_LEN_W) ? MAX_LEN_W : cmd_len_i;

`ifdef DOT8_ACC_SAT_EN
    sum_ext = {acc_q[31], acc_q} + {pe_result_i[31], pe_result_i};
    sat_hit = sum_ext[32] ^ sum_ext[31];
    if (sat_hit) acc_sum = sum_ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else         acc_sum = sum_ext[31:0];
    sat_d = sat_q;
    if (cmd_fire)               sat_d = 1'b0;
    else if (acc_hit & sat_hit) sat_d = 1'b1;
`else
    acc_sum = acc_q + pe_result_i;
`endif

    acc_d = acc_q;
    if (cmd_fire)     acc_d = cmd_init_i;
    else if (acc_hit) acc_d = acc_sum;

    // shadow valid bits track which PE slots hold real operands
    vld_d = vld_q;
    if (pe_enable_q) vld_d = LATENCY'({vld_q, op_fire});

    rem_d = rem_q;
    if (cmd_fire)     rem_d = len_clamped;
    else if (op_fire) rem_d = rem_q - LEN_W'(1);

    out_d = out_q;
    if (op_fire && !acc_hit)      out_d = out_q + OUT_W'(1);
    else if (!op_fire && acc_hit) out_d = out_q - OUT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      op_ready_q  <= 1'b0;
      pe_enable_q <= 1'b0;
      res_valid_q <= 1'b0;
      rem_q       <= '0;
      out_q       <= '0;
      vld_q       <= '0;
      acc_q       <= '0;
      res_data_q  <= '0;
      tag_q       <= '0;
      res_tag_q   <= '0;
`ifdef DOT8_ACC_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      vld_q <= vld_d;
      rem_q <= rem_d;
      out_q <= out_d;
`ifdef DOT8_ACC_SAT_EN
      sat_q <= sat_d;
`endif
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            tag_q       <= cmd_tag_i;
            cmd_ready_q <= 1'b0;
            if (len_clamped != '0) begin
              state_q     <= ISSUE;
              op_ready_q  <= 1'b1;
              pe_enable_q <= 1'b1;
            end else begin
              state_q     <= DONE;
              res_valid_q <= 1'b1;
              res_data_q  <= acc_d;
              res_tag_q   <= cmd_tag_i;
            end
          end
        end
        ISSUE: begin
          if (op_fire && rem_q == LEN_W'(1)) begin
            state_q    <= DRAIN;
            op_ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (acc_hit && out_q == OUT_W'(1)) begin
            state_q     <= DONE;
            pe_enable_q <= 1'b0;
            res_valid_q <= 1'b1;
            res_data_q  <= acc_d;
            res_tag_q   <= tag_q;
          end
        end
        DONE: begin
          if (res_fire) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign op_ready_o  = op_ready_q;
  assign pe_enable_o = pe_enable_q;
  assign pe_a_o      = op_a_i;
  assign pe_b_o      = op_b_i;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_tag_o   = res_tag_q;
`ifdef DOT8_ACC_SAT_EN
  assign sat_flag_o  = sat_q;
`endif

endmodule

// File: tb/tb_dot8_accum_seq.sv
// Bench for dot8_accum_seq: behavioural PE plus a plain-arithmetic dot-product reference.
module tb_dot8_accum_seq;
  localparam int LATENCY   = 2;
  localparam int MAX_LEN   = 64;
  localparam int TAG_WIDTH = 8;
  localparam int LEN_W     = $clog2(MAX_LEN+1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cmd_valid, cmd_ready;
  logic [LEN_W-1:0]     cmd_len;
  logic [31:0]          cmd_init;
  logic [TAG_WIDTH-1:0] cmd_tag;
  logic                 op_valid, op_ready;
  logic [31:0]          op_a, op_b;
  logic                 pe_enable;
  logic [31:0]          pe_a, pe_b, pe_result;
  logic                 res_valid, res_ready;
  logic [31:0]          res_data;
  logic [TAG_WIDTH-1:0] res_tag;
`ifdef DOT8_ACC_SAT_EN
  logic                 sat_flag;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dot8_accum_seq #(.LATENCY(LATENCY), .MAX_LEN(MAX_LEN), .TAG_WIDTH(TAG_WIDTH)) dut (
    .clk_i(clk), .reset_i(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_len_i(cmd_len), .cmd_init_i(cmd_init), .cmd_tag_i(cmd_tag),
    .op_valid_i(op_valid), .op_ready_o(op_ready), .op_a_i(op_a), .op_b_i(op_b),
    .pe_enable_o(pe_enable), .pe_a_o(pe_a), .pe_b_o(pe_b), .pe_result_i(pe_result),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_tag_o(res_tag)
`ifdef DOT8_ACC_SAT_EN
    , .sat_flag_o(sat_flag)
`endif
  );

  function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
    return 32'(s);
  endfunction

  // External PE: LATENCY enabled edges from presentation to pe_result, never reset.
  logic [31:0] pe_pipe [LATENCY];
  always @(posedge clk) begin
    if (pe_enable) begin
      for (int i = LATENCY-1; i > 0; i--) pe_pipe[i] <= pe_pipe[i-1];
      pe_pipe[0] <= dot4(pe_a, pe_b);
    end
  end
  assign pe_result = pe_pipe[LATENCY-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // mode: 0 operand every cycle, 1 alternating 1,0,1,0, 2 random gaps
  task automatic run_cmd(input int len, input logic [31:0] init, input logic [7:0] tag,
                         input int mode, input int hold, input logic [31:0] fa,
                         input logic [31:0] fb, input bit fixed);
    int n, idx, e, last_e, guard;
    logic [31:0] oa[$], ob[$];
    logic [31:0] a, b, exp_data;
    longint m;
    bit exp_sat, v;
    n = (len > MAX_LEN) ? MAX_LEN : len;
    exp_sat = 1'b0;
    m = longint'($signed(init));
    for (int i = 0; i < n; i++) begin
      a = fixed ? fa : $urandom;
      b = fixed ? fb : $urandom;
      oa.push_back(a);
      ob.push_back(b);
      m += longint'($signed(dot4(a, b)));
`ifdef DOT8_ACC_SAT_EN
      if (m > 64'sd2147483647) begin m = 64'sd2147483647; exp_sat = 1'b1; end
      else if (m < -64'sd2147483648) begin m = -64'sd2147483648; exp_sat = 1'b1; end
`endif
    end
    exp_data = 32'(m);

    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    cmd_init  = init;
    cmd_tag   = tag;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    e = 0;
    last_e = 0;
    if (n > 0) begin
      check("issue_pe_enable", 32'(pe_enable), 32'd1);
      idx = 0;
      guard = 0;
      while (idx < n && guard < 4*MAX_LEN + 16) begin
        v = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
        op_valid = v;
        op_a = v ? oa[idx] : $urandom;
        op_b = v ? ob[idx] : $urandom;
        check("issue_op_ready", 32'(op_ready), 32'd1);
        if (guard == 0) check("pe_a_pass", pe_a, op_a);
        @(posedge clk); e++; guard++; #1;
        if (v) begin idx++; last_e = e; end
      end
      op_valid = 1'b0;
      check("all_ops_issued", idx, n);
      check("op_ready_drop", 32'(op_ready), 32'd0);
      check("drain_pe_enable", 32'(pe_enable), 32'd1);
    end
    guard = 0;
    while (!res_valid && guard < LATENCY + MAX_LEN + 20) begin
      @(posedge clk); e++; guard++; #1;
    end
    check("res_valid_seen", 32'(res_valid), 32'd1);
    check("res_latency", e, (n == 0) ? 0 : last_e + LATENCY);
    check("res_data", res_data, exp_data);
    check("res_tag", 32'(res_tag), 32'(tag));
    check("done_cmd_ready", 32'(cmd_ready), 32'd0);
    check("done_pe_enable", 32'(pe_enable), 32'd0);
`ifdef DOT8_ACC_SAT_EN
    check("sat_flag", 32'(sat_flag), 32'(exp_sat));
`endif
    cmd_valid = 1'b1;
    cmd_tag   = ~tag;
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_res_valid", 32'(res_valid), 32'd1);
      check("hold_res_data", res_data, exp_data);
      check("hold_res_tag", 32'(res_tag), 32'(tag));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("handshake_clear", 32'(res_valid), 32'd0);
    check("back_to_idle", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_init  = '0;
    cmd_tag   = '0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_op_ready", 32'(op_ready), 32'd0);
    check("rst_pe_enable", 32'(pe_enable), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_tag", 32'(res_tag), 32'd0);
    reset = 1'b1;

    run_cmd(1, 32'd0, 8'h5A, 0, 0, 32'h0102_0304, 32'h0101_0101, 1'b1);
    run_cmd(3, 32'd100, 8'h11, 0, 0, 32'h8080_8080, 32'h7F7F_7F7F, 1'b1);
    run_cmd(4, 32'h0000_1000, 8'h22, 1, 0, 32'd0, 32'd0, 1'b0);
    run_cmd(0, 32'h1234_5678, 8'h33, 0, 0, 32'd0, 32'd0, 1'b0);
    run_cmd(2, $urandom, 8'h44, 0, 5, 32'd0, 32'd0, 1'b0);

    // reset in the middle of ISSUE with operands already inside the PE
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(5);
    cmd_init  = 32'hDEAD_BEEF;
    cmd_tag   = 8'h77;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    op_valid  = 1'b1;
    op_a      = 32'h7F7F_7F7F;
    op_b      = 32'h7F7F_7F7F;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    reset = 1'b1;
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_op_ready", 32'(op_ready), 32'd0);
    check("midrst_pe_enable", 32'(pe_enable), 32'd0);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    check("midrst_res_data", res_data, 32'd0);
    check("midrst_res_tag", 32'(res_tag), 32'd0);
    run_cmd(3, 32'd7, 8'h88, 0, 0, 32'd0, 32'd0, 1'b0);

    run_cmd(1, 32'h7FFF_FF00, 8'h55, 0, 0, 32'h1010_1010, 32'h0808_0808, 1'b1);
    run_cmd(1, 32'h8000_0100, 8'h56, 0, 0, 32'h1010_1010, 32'hF8F8_F8F8, 1'b1);
    run_cmd(70, $urandom, 8'h66, 0, 0, 32'd0, 32'd0, 1'b0);

    for (int t = 0; t < 6; t++)
      run_cmd($urandom_range(1, 12), $urandom, 8'($urandom), 2, $urandom_range(0, 2),
              32'd0, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
